dat_mem_arb: RTL and testbench

Two-requester access arbiter and sequencer for the 256-byte data memory. It accepts load and store requests from port 0 (processor load/store unit) and port 1 (loader/debug or DMA agent), picks one winner, and drives the memory's `dat_in`/`wr_en`/`addr`/`immed` inputs for exactly one access cycle. It then returns a registered acknowledge, plus registered read data, to the winner. It sits directly in front of the data memory and is the only block permitted to drive its write enable.

---
 rtl/dat_mem_arb.sv | 108 ++++++++++
 tb/tb_dat_mem_arb.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dat_mem_arb.sv
// dat_mem_arb: two-port load/store arbiter and one-cycle sequencer in front of the data memory.
// Define DAT_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dat_mem_arb #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic [W-1:0] addr0,
  input  logic [W-1:0] addr1,
  input  logic [W-1:0] immed0,
  input  logic [W-1:0] immed1,
  input  logic [W-1:0] wdata0,
  input  logic [W-1:0] wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] rdata0,
  output logic [W-1:0] rdata1,
  output logic [W-1:0] mem_dat_in,
  output logic         mem_wr_en,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_immed,
  input  logic [W-1:0] mem_dat_out
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic cmd_port_q, cmd_port_d, cmd_we_q, cmd_we_d;
  logic [W-1:0] cmd_addr_q, cmd_addr_d, cmd_immed_q, cmd_immed_d, cmd_wdata_q, cmd_wdata_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d;
  logic [W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic elig0, elig1, grant, win;
  // A port is masked in its own ack cycle so a held req is not re-granted.
  assign elig0 = req0 & ~ack0_q;
  assign elig1 = req1 & ~ack1_q;
  assign grant = (state_q == IDLE) & (elig0 | elig1);
`ifdef DAT_ARB_RR_EN
  logic last_q, last_d;
  assign win    = (elig0 & elig1) ? ~last_q : elig1;
  assign last_d = grant ? win : last_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_q <= 1'b1;
    else last_q <= last_d;
`else
  assign win = elig1 & ~elig0;
`endif
  always_comb begin
    state_d     = state_q;
    cmd_port_d  = cmd_port_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_immed_d = cmd_immed_q;
    cmd_wdata_d = cmd_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    if (grant) begin
      state_d     = ACCESS;
      cmd_port_d  = win;
      cmd_we_d    = win ? we1 : we0;
      cmd_addr_d  = win ? addr1 : addr0;
      cmd_immed_d = win ? immed1 : immed0;
      cmd_wdata_d = win ? wdata1 : wdata0;
    end else if (state_q == ACCESS) begin
      state_d  = IDLE;
      ack0_d   = ~cmd_port_q;
      ack1_d   = cmd_port_q;
      rdata0_d = (!cmd_we_q && !cmd_port_q) ? mem_dat_out : rdata0_q;
      rdata1_d = (!cmd_we_q && cmd_port_q) ? mem_dat_out : rdata1_q;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_immed_q <= '0;
      cmd_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_immed_q <= cmd_immed_d;
      cmd_wdata_q <= cmd_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  // Write enable is combinational on state so an async reset drops it at once.
  assign mem_wr_en  = (state_q == ACCESS) & cmd_we_q;
  assign mem_addr   = cmd_addr_q;
  assign mem_immed  = cmd_immed_q;
  assign mem_dat_in = cmd_wdata_q;
endmodule

// File: tb/tb_dat_mem_arb.sv
// tb_dat_mem_arb: directed self-checking bench for dat_mem_arb with a 256-byte memory model.
module tb_dat_mem_arb;
  logic clk = 1'b0, reset = 1'b1, init = 1'b1;
  logic req0, req1, we0, we1, ack0, ack1, mem_wr_en;
  logic [7:0] addr0, addr1, immed0, immed1, wdata0, wdata1, rdata0, rdata1;
  logic [7:0] mem_dat_in, mem_addr, mem_immed, mem_dat_out, ea;
  logic [7:0] mem [256];
  int tests = 0, fails = 0, ack1_cnt;
  bit f;
  logic [1:0] e;

  dat_mem_arb #(.W(8)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .immed0(immed0), .immed1(immed1),
    .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_dat_in(mem_dat_in), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_immed(mem_immed), .mem_dat_out(mem_dat_out)
  );

  always #5 clk = ~clk;

  assign ea = mem_addr + mem_immed;
  assign mem_dat_out = mem[ea];
  always @(posedge clk)
    if (init) for (int i = 0; i < 256; i++) mem[i] <= ~i[7:0];
    else if (mem_wr_en) mem[ea] <= mem_dat_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit p, input bit r, input bit w, input logic [7:0] a, input logic [7:0] i, input logic [7:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; immed1 = i; wdata1 = d; end
    else begin req0 = r; we0 = w; addr0 = a; immed0 = i; wdata0 = d; end
  endtask

  task automatic setreq(input bit p, input bit r);
    if (p) req1 = r; else req0 = r;
  endtask

  task automatic do_single(input string tag, input bit p, input bit w, input logic [7:0] a,
                           input logic [7:0] i, input logic [7:0] d, input logic [7:0] exp);
    @(posedge clk); #1 drive(p, 1'b1, w, a, i, d);
    @(negedge clk);
    check({tag, "_t0_ack"}, {ack1, ack0}, 2'b00);
    check({tag, "_t0_we"}, mem_wr_en, 1'b0);
    @(negedge clk);
    check({tag, "_t1_we"}, mem_wr_en, w);
    check({tag, "_t1_addr"}, mem_addr, a);
    check({tag, "_t1_immed"}, mem_immed, i);
    if (w) check({tag, "_t1_din"}, mem_dat_in, d);
    @(negedge clk);
    check({tag, "_t2_ack"}, {ack1, ack0}, p ? 2'b10 : 2'b01);
    check({tag, "_t2_we"}, mem_wr_en, 1'b0);
    if (!w) check({tag, "_t2_rdata"}, p ? rdata1 : rdata0, exp);
    @(posedge clk); #1 setreq(p, 1'b0);
  endtask

  initial begin
    @(posedge clk); #1 init = 1'b0;
  end

  initial begin
    drive(1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (3) begin
      @(negedge clk);
      check("rst_ack", {ack1, ack0}, 2'b00);
      check("rst_we", mem_wr_en, 1'b0);
      check("rst_rdata", {rdata1, rdata0}, 16'h0000);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); check("rel_r0_ack", ack0, 1'b0);
    @(negedge clk); check("rel_r1_ack", ack0, 1'b0);
    @(negedge clk); check("rel_r2_ack", ack0, 1'b1);
    check("rel_r2_rdata", rdata0, 8'hCC);
    @(posedge clk); #1 setreq(1'b0, 1'b0);

    do_single("st0", 1'b0, 1'b1, 8'h10, 8'h05, 8'hA5, 8'h00);
    do_single("ld0", 1'b0, 1'b0, 8'h10, 8'h05, 8'h00, 8'hA5);
    do_single("wrap_st1", 1'b1, 1'b1, 8'hF0, 8'h20, 8'h3C, 8'h00);
    check("wrap_rdata1_kept", rdata1, 8'h00);
    do_single("wrap_ld0", 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h3C);

    // Port 0 was served last, so round-robin hands the tie to port 1.
`ifdef DAT_ARB_RR_EN
    f = 1'b1;
`else
    f = 1'b0;
`endif
    @(posedge clk); #1 drive(1'b0, 1'b1, 1'b0, 8'h15, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      e = (k >= 2 && k % 2 == 0) ? ((f ^ 1'(((k / 2) - 1) & 1)) ? 2'b10 : 2'b01) : 2'b00;
      check($sformatf("cont_ack_c%0d", k), {ack1, ack0}, e);
      if (e == 2'b01) check($sformatf("cont_rd0_c%0d", k), rdata0, 8'hA5);
      if (e == 2'b10) check($sformatf("cont_rd1_c%0d", k), rdata1, 8'h3C);
    end
    @(posedge clk); #1 setreq(1'b0, 1'b0); setreq(1'b1, 1'b0);
    repeat (4) @(posedge clk);

    #1 drive(1'b0, 1'b1, 1'b1, 8'h40, 8'h00, 8'h77);
    @(posedge clk); #1 check("mr_we_pre", mem_wr_en, 1'b1);
    reset = 1'b1; setreq(1'b0, 1'b0);
    #1 check("mr_we_drop", mem_wr_en, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("mr_ack", {ack1, ack0}, 2'b00);
      check("mr_we", mem_wr_en, 1'b0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); check("mr_post_ack", {ack1, ack0}, 2'b00);
    do_single("mr_ld", 1'b0, 1'b0, 8'h40, 8'h00, 8'h00, 8'hBF);

    @(posedge clk); #1 drive(1'b0, 1'b1, 1'b1, 8'h50, 8'h00, 8'h11);
    @(posedge clk); #1 drive(1'b1, 1'b1, 1'b1, 8'h60, 8'h00, 8'h22);
    ack1_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (ack1) ack1_cnt++;
      if (k == 2) begin
        check("pend_ack0", {ack1, ack0}, 2'b01);
        setreq(1'b0, 1'b0);
      end
      if (k == 3) begin
        check("pend_we1", mem_wr_en, 1'b1);
        check("pend_addr1", mem_addr, 8'h60);
        check("pend_din1", mem_dat_in, 8'h22);
      end
      if (k == 4) setreq(1'b1, 1'b0);
    end
    check("pend_ack1_cnt", ack1_cnt, 1);
    do_single("pend_ld0", 1'b0, 1'b0, 8'h50, 8'h00, 8'h00, 8'h11);
    do_single("pend_ld1", 1'b1, 1'b0, 8'h60, 8'h00, 8'h00, 8'h22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
